// File: rtl/ssb_sync_ctrl_pkg.sv
// Shared types and constants for the SSB cell-search sequencer.
// Covers the state encoding, the N_id ranges and the N_id formula.
package sync_pkg;

  localparam int N_ID_W     = 10;
  localparam int N_ID_1_W   = 9;
  localparam int N_ID_1_MAX = 335;
  localparam int N_ID_2_MAX = 2;
  localparam int N_ID_MAX   = 1007;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_SSS = 3'd1,
    SKIP     = 3'd2,
    COLLECT  = 3'd3,
    WAIT_DET = 3'd4
  } sync_state_t;

  function automatic logic [N_ID_W-1:0] calc_n_id(input logic [N_ID_1_W-1:0] n_id_1,
                                                  input logic [1:0]          n_id_2);
    return N_ID_W'(n_id_1) * N_ID_W'(3) + N_ID_W'(n_id_2);
  endfunction

endpackage

// File: rtl/ssb_sync_ctrl_if.sv
// Bundle of the PSS, FFT and SSS-detector signals around the sequencer.
// The master side is the environment, and the slave side is the sequencer.
interface ssb_sync_if
  import sync_pkg::*;
#(
  parameter int FFT_DW = 32
) ();

  logic [1:0]          N_id_2_i;
  logic                N_id_2_valid_i;
  logic                SSS_start_i;
  logic [FFT_DW-1:0]   fft_tdata_i;
  logic                fft_tvalid_i;
  logic [N_ID_1_W-1:0] det_N_id_1_i;
  logic                det_valid_i;

  logic [1:0]          N_id_2_o;
  logic                N_id_2_valid_o;
  logic                sss_bit_o;
  logic                sss_bit_valid_o;
  logic [N_ID_W-1:0]   N_id_o;
  logic                N_id_valid_o;
  logic                locked_o;
  logic                timeout_o;
  logic [2:0]          state_o;

  modport master (
    output N_id_2_i, N_id_2_valid_i, SSS_start_i, fft_tdata_i, fft_tvalid_i,
           det_N_id_1_i, det_valid_i,
    input  N_id_2_o, N_id_2_valid_o, sss_bit_o, sss_bit_valid_o, N_id_o,
           N_id_valid_o, locked_o, timeout_o, state_o
  );

  modport slave (
    input  N_id_2_i, N_id_2_valid_i, SSS_start_i, fft_tdata_i, fft_tvalid_i,
           det_N_id_1_i, det_valid_i,
    output N_id_2_o, N_id_2_valid_o, sss_bit_o, sss_bit_valid_o, N_id_o,
           N_id_valid_o, locked_o, timeout_o, state_o
  );

endinterface

// File: rtl/ssb_sync_ctrl_lock_tracker.sv
// Tracks how many consecutive accepted SSBs produced the same N_id.
// locked is raised once LOCK_CNT consecutive results agree.
module ssb_lock_tracker
  import sync_pkg::*;
#(
  parameter int LOCK_CNT = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              i_update,
  input  logic              i_clear,
  input  logic [N_ID_W-1:0] i_N_id,
  output logic              o_locked
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CNT);

  logic [N_ID_W-1:0] r_last;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_locked;
  logic [CNT_W-1:0]  w_next;

  // A repeat of the stored N_id extends the run (saturating); anything else restarts it.
  always_comb begin
    w_next = CNT_W'(1);
    if (i_N_id == r_last)
      w_next = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_last   <= '0;
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else if (i_clear) begin
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else if (i_update) begin
      r_last   <= i_N_id;
      r_cnt    <= w_next;
      r_locked <= (w_next == CNT_MAX);
    end
  end

  assign o_locked = r_locked;

endmodule

// File: rtl/ssb_sync_ctrl.sv
// Cell-search sequencer: it latches N_id_2 from a PSS peak and slices the SSS bins into bits.
// It then forms N_id from the SSS detector result and reports lock over successive SSBs.
module ssb_sync_ctrl
  import sync_pkg::*;
#(
  parameter int FFT_DW      = 32,
  parameter int SSS_START   = 64,
  parameter int SSS_LEN     = 127,
  parameter int TIMEOUT_CYC = 4096,
  parameter int LOCK_CNT    = 3
) (
  input logic       clk_i,
  input logic       reset_i,
  ssb_sync_if.slave bus
);

  localparam int BIN_W = $clog2((SSS_START > SSS_LEN ? SSS_START : SSS_LEN) + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BIN_W-1:0] SKIP_LAST = BIN_W'(SSS_START - 1);
  localparam logic [BIN_W-1:0] BITS_LAST = BIN_W'(SSS_LEN - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  sync_state_t       r_state;
  logic [BIN_W-1:0]  r_bin;
  logic [TMO_W-1:0]  r_tmo;
  logic [1:0]        r_N_id_2;
  logic              r_N_id_2_valid;
  logic              r_sss_bit;
  logic              r_sss_bit_valid;
  logic [N_ID_W-1:0] r_N_id;
  logic              r_N_id_valid;
  logic              r_timeout;

  logic              w_det;
  logic              w_accept;
  logic              w_tmo_evt;
  logic              w_clear;
  logic              w_locked;
  logic [N_ID_W-1:0] w_N_id;

  // SSS_start_i and det_valid_i take priority over an expiring timeout in the same cycle.
  assign w_det     = (r_state == WAIT_DET) && bus.det_valid_i;
  assign w_accept  = w_det && (bus.det_N_id_1_i <= N_ID_1_W'(N_ID_1_MAX));
  assign w_tmo_evt = (r_tmo == TMO_LAST) &&
                     (((r_state == WAIT_SSS) && !bus.SSS_start_i) ||
                      ((r_state == WAIT_DET) && !bus.det_valid_i));
  assign w_clear   = (w_det && !w_accept) || w_tmo_evt;
  assign w_N_id    = calc_n_id(bus.det_N_id_1_i, r_N_id_2);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state         <= IDLE;
      r_bin           <= '0;
      r_tmo           <= '0;
      r_N_id_2        <= '0;
      r_N_id_2_valid  <= 1'b0;
      r_sss_bit       <= 1'b0;
      r_sss_bit_valid <= 1'b0;
      r_N_id          <= '0;
      r_N_id_valid    <= 1'b0;
      r_timeout       <= 1'b0;
    end else begin
      r_N_id_2_valid  <= 1'b0;
      r_sss_bit_valid <= 1'b0;
      r_N_id_valid    <= 1'b0;
      r_timeout       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.N_id_2_valid_i && (bus.N_id_2_i <= 2'(N_ID_2_MAX))) begin
            r_N_id_2       <= bus.N_id_2_i;
            r_N_id_2_valid <= 1'b1;
            r_tmo          <= '0;
            r_state        <= WAIT_SSS;
          end
        end
        WAIT_SSS: begin
          if (bus.SSS_start_i) begin
            r_bin   <= '0;
            r_tmo   <= '0;
            r_state <= SKIP;
          end else if (w_tmo_evt) begin
            r_timeout <= 1'b1;
            r_tmo     <= '0;
            r_state   <= IDLE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        SKIP: begin
          if (bus.fft_tvalid_i) begin
            if (r_bin == SKIP_LAST) begin
              r_bin   <= '0;
              r_tmo   <= '0;
              r_state <= COLLECT;
            end else begin
              r_bin <= r_bin + BIN_W'(1);
            end
          end
        end
        COLLECT: begin
          if (bus.fft_tvalid_i) begin
            r_sss_bit       <= ~bus.fft_tdata_i[FFT_DW/2-1];
            r_sss_bit_valid <= 1'b1;
            if (r_bin == BITS_LAST) begin
              r_bin   <= '0;
              r_tmo   <= '0;
              r_state <= WAIT_DET;
            end else begin
              r_bin <= r_bin + BIN_W'(1);
            end
          end
        end
        WAIT_DET: begin
          if (w_det) begin
            if (w_accept) begin
              r_N_id       <= w_N_id;
              r_N_id_valid <= 1'b1;
            end
            r_tmo   <= '0;
            r_state <= IDLE;
          end else if (w_tmo_evt) begin
            r_timeout <= 1'b1;
            r_tmo     <= '0;
            r_state   <= IDLE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  ssb_lock_tracker #(
    .LOCK_CNT (LOCK_CNT)
  ) u_lock (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .i_update (w_accept),
    .i_clear  (w_clear),
    .i_N_id   (w_N_id),
    .o_locked (w_locked)
  );

  assign bus.N_id_2_o        = r_N_id_2;
  assign bus.N_id_2_valid_o  = r_N_id_2_valid;
  assign bus.sss_bit_o       = r_sss_bit;
  assign bus.sss_bit_valid_o = r_sss_bit_valid;
  assign bus.N_id_o          = r_N_id;
  assign bus.N_id_valid_o    = r_N_id_valid;
  assign bus.locked_o        = w_locked;
  assign bus.timeout_o       = r_timeout;
  assign bus.state_o         = r_state;

endmodule

// File: tb/tb_ssb_sync_ctrl.sv
// Self-checking bench for ssb_sync_ctrl: table-driven SSBs, timeout/reset corner sequences,
// and randomized SSBs compared against a lock/N_id reference model.
module tb_ssb_sync_ctrl;
  import sync_pkg::*;

  localparam int FFT_DW      = 32;
  localparam int SSS_START   = 64;
  localparam int SSS_LEN     = 127;
  localparam int TIMEOUT_CYC = 200;
  localparam int LOCK_CNT    = 3;
  localparam int NBINS       = SSS_START + SSS_LEN;

  typedef struct {
    int n2;
    int n1;
    int gap;
    bit rnd;
    bit peak;
    int expValid;
    int expNid;
    int expLocked;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ssb_sync_if #(.FFT_DW(FFT_DW)) sif ();

  ssb_sync_ctrl #(
    .FFT_DW      (FFT_DW),
    .SSS_START   (SSS_START),
    .SSS_LEN     (SSS_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .LOCK_CNT    (LOCK_CNT)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (sif.slave)
  );

  int nErrors = 0;
  int nChecks = 0;

  bit gotBits[$];
  int nidCnt = 0, nidVal = 0, n2Cnt = 0, n2Val = 0, tmoCnt = 0;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (sif.sss_bit_valid_o) gotBits.push_back(sif.sss_bit_o);
    if (sif.N_id_valid_o) begin
      nidCnt++;
      nidVal = int'(sif.N_id_o);
    end
    if (sif.N_id_2_valid_o) begin
      n2Cnt++;
      n2Val = int'(sif.N_id_2_o);
    end
    if (sif.timeout_o) tmoCnt++;
  end

  logic [FFT_DW-1:0] binsSent[$];
  int mLast = 0, mCnt = 0, mNidOut = 0;
  int eValid, eNid, eLocked;
  int rBitCnt, rBitErr, rNidCnt, rNid, rN2Cnt, rN2, rLocked, rNidHold;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int got, input int exp);
    nChecks++;
    if (got != exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic doPeak(input int n2);
    sif.N_id_2_i       = 2'(n2);
    sif.N_id_2_valid_i = 1'b1;
    step();
    sif.N_id_2_valid_i = 1'b0;
  endtask

  task automatic doStart();
    step();
    sif.SSS_start_i = 1'b1;
    step();
    sif.SSS_start_i = 1'b0;
  endtask

  task automatic driveBins(input int count, input int gap, input bit rnd,
                           input int peakAt, input int peakN2);
    logic [FFT_DW-1:0] d;
    for (int k = 1; k <= count; k++) begin
      for (int g = 1; g < gap; g++) begin
        sif.fft_tvalid_i = 1'b0;
        sif.fft_tdata_i  = $urandom;
        step();
      end
      if (rnd) d = $urandom;
      else     d = {16'($urandom), ((k % 2) == 1) ? 16'h1234 : 16'hF234};
      sif.fft_tdata_i  = d;
      sif.fft_tvalid_i = 1'b1;
      if (k == peakAt) begin
        sif.N_id_2_i       = 2'(peakN2);
        sif.N_id_2_valid_i = 1'b1;
      end
      binsSent.push_back(d);
      step();
      sif.fft_tvalid_i   = 1'b0;
      sif.N_id_2_valid_i = 1'b0;
    end
  endtask

  task automatic doDet(input int n1);
    sif.det_N_id_1_i = 9'(n1);
    sif.det_valid_i  = 1'b1;
    step();
    sif.det_valid_i  = 1'b0;
    step();
  endtask

  // Reference: bits are the signs of bins SSS_START+1.., N_id = 3*N_id_1+N_id_2, lock is a run length.
  task automatic modelResult(input int n2, input int n1);
    int nid;
    if (n1 <= N_ID_1_MAX) begin
      nid = 3 * n1 + n2;
      if (nid == mLast) mCnt = (mCnt + 1 > LOCK_CNT) ? LOCK_CNT : mCnt + 1;
      else              mCnt = 1;
      mLast   = nid;
      mNidOut = nid;
      eValid  = 1;
    end else begin
      mCnt   = 0;
      eValid = 0;
    end
    eNid    = mNidOut;
    eLocked = (mCnt == LOCK_CNT) ? 1 : 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int bitBase, nidBase, n2Base;
    bitBase = gotBits.size();
    nidBase = nidCnt;
    n2Base  = n2Cnt;
    binsSent.delete();
    doPeak(v.n2);
    doStart();
    driveBins(NBINS, v.gap, v.rnd, v.peak ? 100 : 0, (v.n2 + 1) % 3);
    step();
    doDet(v.n1);
    rBitCnt = gotBits.size() - bitBase;
    rBitErr = -1;
    for (int i = 0; i < SSS_LEN && i < rBitCnt; i++)
      if (rBitErr < 0 && gotBits[bitBase+i] != !binsSent[SSS_START+i][FFT_DW/2-1]) rBitErr = i;
    rNidCnt  = nidCnt - nidBase;
    rNid     = nidVal;
    rN2Cnt   = n2Cnt - n2Base;
    rN2      = n2Val;
    rLocked  = int'(sif.locked_o);
    rNidHold = int'(sif.N_id_o);
    modelResult(v.n2, v.n1);
  endtask

  task automatic checkSsb(input vec_t v, input int expValid, input int expNid, input int expLocked);
    checkOutput("bit_count", rBitCnt, SSS_LEN);
    checkOutput("first_bad_bit", rBitErr, -1);
    checkOutput("n2_strobes", rN2Cnt, 1);
    checkOutput("n2_value", rN2, v.n2);
    checkOutput("nid_strobes", rNidCnt, expValid);
    if (expValid != 0) checkOutput("nid_strobe_value", rNid, expNid);
    checkOutput("nid_held", rNidHold, expNid);
    checkOutput("locked", rLocked, expLocked);
    checkOutput("state_idle", int'(sif.state_o), 0);
  endtask

  initial begin
    vec_t vecs[14];
    vec_t v;
    int n2Base, tmoBase, bitBase, nidBase, prevN1, prevN2;

    vecs[0]  = '{1, 100, 1, 1'b0, 1'b0, 1, 301, 0};
    vecs[1]  = '{1, 100, 3, 1'b0, 1'b0, 1, 301, 0};
    vecs[2]  = '{1, 100, 2, 1'b1, 1'b0, 1, 301, 1};
    vecs[3]  = '{2, 100, 1, 1'b1, 1'b0, 1, 302, 0};
    vecs[4]  = '{0, 400, 1, 1'b1, 1'b0, 0, 302, 0};
    vecs[5]  = '{0, 335, 1, 1'b0, 1'b1, 1, 1005, 0};
    vecs[6]  = '{2, 335, 1, 1'b1, 1'b0, 1, 1007, 0};
    vecs[7]  = '{2, 335, 2, 1'b1, 1'b1, 1, 1007, 0};
    vecs[8]  = '{2, 335, 1, 1'b1, 1'b0, 1, 1007, 1};
    vecs[9]  = '{2, 336, 1, 1'b1, 1'b0, 0, 1007, 0};
    vecs[10] = '{0, 0, 1, 1'b1, 1'b0, 1, 0, 0};
    vecs[11] = '{0, 0, 3, 1'b1, 1'b0, 1, 0, 0};
    vecs[12] = '{0, 0, 1, 1'b1, 1'b0, 1, 0, 1};
    vecs[13] = '{1, 100, 1, 1'b0, 1'b0, 1, 301, 0};

    reset              = 1'b1;
    sif.N_id_2_i       = '0;
    sif.N_id_2_valid_i = 1'b0;
    sif.SSS_start_i    = 1'b0;
    sif.fft_tdata_i    = '0;
    sif.fft_tvalid_i   = 1'b0;
    sif.det_N_id_1_i   = '0;
    sif.det_valid_i    = 1'b0;
    repeat (3) step();

    checkOutput("reset_state", int'(sif.state_o), 0);
    checkOutput("reset_strobes", int'({sif.N_id_2_valid_o, sif.sss_bit_valid_o,
                                       sif.N_id_valid_o, sif.timeout_o}), 0);
    checkOutput("reset_data", int'({sif.N_id_2_o, sif.sss_bit_o, sif.N_id_o, sif.locked_o}), 0);
    reset = 1'b0;
    step();

    // N_id_2 == 3 must not start a search.
    n2Base = n2Cnt;
    doPeak(3);
    step();
    checkOutput("n2_3_state", int'(sif.state_o), 0);
    checkOutput("n2_3_strobe", n2Cnt - n2Base, 0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkSsb(vecs[i], vecs[i].expValid, vecs[i].expNid, vecs[i].expLocked);
    end

    // Timeout in WAIT_SSS while locked.
    checkOutput("locked_before_tmo", int'(sif.locked_o), 1);
    tmoBase = tmoCnt;
    doPeak(1);
    repeat (TIMEOUT_CYC - 1) step();
    checkOutput("wait_sss_no_tmo_yet", int'(sif.timeout_o), 0);
    checkOutput("wait_sss_state", int'(sif.state_o), 1);
    step();
    checkOutput("wait_sss_tmo", int'(sif.timeout_o), 1);
    checkOutput("wait_sss_tmo_state", int'(sif.state_o), 0);
    checkOutput("wait_sss_tmo_unlock", int'(sif.locked_o), 0);
    step();
    checkOutput("tmo_one_cycle", tmoCnt - tmoBase, 1);
    mCnt = 0;

    // SSS_start_i on the expiry cycle wins over the timeout.
    tmoBase = tmoCnt;
    doPeak(2);
    repeat (TIMEOUT_CYC - 1) step();
    sif.SSS_start_i = 1'b1;
    step();
    sif.SSS_start_i = 1'b0;
    checkOutput("start_at_expiry_state", int'(sif.state_o), 2);
    checkOutput("start_at_expiry_no_tmo", tmoCnt - tmoBase, 0);
    bitBase = gotBits.size();
    nidBase = nidCnt;
    binsSent.delete();
    driveBins(NBINS, 1, 1'b1, 0, 0);
    step();
    doDet(7);
    modelResult(2, 7);
    checkOutput("expiry_ssb_bits", gotBits.size() - bitBase, SSS_LEN);
    checkOutput("expiry_ssb_nid", nidVal, 23);
    checkOutput("expiry_ssb_nid_cnt", nidCnt - nidBase, 1);

    // Timeout in WAIT_DET.
    tmoBase = tmoCnt;
    doPeak(0);
    doStart();
    driveBins(NBINS, 1, 1'b1, 0, 0);
    repeat (TIMEOUT_CYC - 1) step();
    checkOutput("wait_det_state", int'(sif.state_o), 4);
    step();
    checkOutput("wait_det_tmo", int'(sif.timeout_o), 1);
    checkOutput("wait_det_tmo_state", int'(sif.state_o), 0);
    checkOutput("wait_det_nid_held", int'(sif.N_id_o), 23);
    step();
    checkOutput("wait_det_tmo_cnt", tmoCnt - tmoBase, 1);
    mCnt = 0;

    // Synchronous reset in the middle of COLLECT.
    doPeak(1);
    doStart();
    driveBins(100, 1, 1'b1, 0, 0);
    checkOutput("pre_reset_state", int'(sif.state_o), 3);
    checkOutput("pre_reset_bit_valid", int'(sif.sss_bit_valid_o), 1);
    reset = 1'b1;
    step();
    checkOutput("reset_mid_bit_valid", int'(sif.sss_bit_valid_o), 0);
    checkOutput("reset_mid_state", int'(sif.state_o), 0);
    checkOutput("reset_mid_nid", int'(sif.N_id_o), 0);
    reset = 1'b0;
    mLast = 0;
    mCnt = 0;
    mNidOut = 0;
    applyStimulus(vecs[13]);
    checkSsb(vecs[13], vecs[13].expValid, vecs[13].expNid, vecs[13].expLocked);

    // Randomized SSBs against the reference model.
    prevN1 = 100;
    prevN2 = 1;
    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 2) != 0) begin
        v.n1 = prevN1;
        v.n2 = prevN2;
      end else begin
        v.n2 = $urandom_range(0, 2);
        v.n1 = ($urandom_range(0, 3) == 0) ? $urandom_range(336, 511) : $urandom_range(0, 335);
      end
      v.gap  = $urandom_range(1, 3);
      v.rnd  = 1'b1;
      v.peak = 1'($urandom_range(0, 1));
      applyStimulus(v);
      checkSsb(v, eValid, eNid, eLocked);
      prevN1 = v.n1;
      prevN2 = v.n2;
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
